uart_tx_stream: RTL

//  AXI-Stream-to-serial UART transmitter; transmit-side counterpart of the UART receive path.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_bit_timer.sv | 18 +
 rtl/uart_tx_stream.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, transmitter FSM states and oversample ratio shared by the UART TX and RX paths.
package uart_pkg;
   localparam int OVERSAMPLE  = 16;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
   function automatic logic parity_bit(input logic [7:0] d, input int mode);
      return (mode == PARITY_ODD) ? ~^d : ^d;
   endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 16x-baud enables and flags the last enable of each bit period.
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic aclk,
   input  logic aresetn,
   input  logic clear,
   input  logic run,
   input  logic tick,
   output logic bit_done
);
   logic [3:0] cnt_q, cnt_d;
   assign bit_done = run && tick && cnt_q == 4'(OVERSAMPLE - 1);
   always_comb cnt_d = clear ? '0 : (run && tick) ? cnt_q + 4'd1 : cnt_q;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: AXI-Stream byte in, LSB-first UART frame out (start/data/parity/stop).
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       clk_en_16_x_baud,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic       UART_TX,
   output logic       tx_busy
);
   localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       par_q, par_d, tx_q, tx_d, rdy_q, rdy_d, busy_q, busy_d;
   logic       accept, bit_done, last_data, last_stop;
   logic [7:0] data_m;
   assign accept    = s_axis_tvalid && rdy_q;
   assign data_m    = s_axis_tdata & DATA_MASK;
   assign last_data = bit_cnt_q == 3'(DATA_BITS - 1);
   assign last_stop = bit_cnt_q == 3'(STOP_BITS - 1);
   // Clearing on accept discards any enable pulse landing on the accept edge.
   uart_bit_timer u_timer (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .clear    (accept),
      .run      (state_q != ST_IDLE),
      .tick     (clk_en_16_x_baud),
      .bit_done (bit_done)
   );
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
      end
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = accept ? ST_START : ST_IDLE;
         ST_START:  state_d = bit_done ? ST_DATA : ST_START;
         ST_DATA:   state_d = (bit_done && last_data) ? ((PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP) : ST_DATA;
         ST_PARITY: state_d = bit_done ? ST_STOP : ST_PARITY;
         ST_STOP:   state_d = (bit_done && last_stop) ? ST_IDLE : ST_STOP;
         default:   state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      tx_d      = tx_q;
      rdy_d     = rdy_q;
      busy_d    = busy_q;
      case (state_q)
         ST_IDLE: begin
            shift_d   = accept ? data_m : shift_q;
            par_d     = accept ? parity_bit(data_m, PARITY) : par_q;
            bit_cnt_d = '0;
            tx_d      = !accept;
            rdy_d     = !accept;
            busy_d    = accept;
         end
         ST_START: tx_d = bit_done ? shift_q[0] : tx_q;
         ST_DATA: if (bit_done) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = last_data ? '0 : bit_cnt_q + 3'd1;
            tx_d      = !last_data ? shift_q[1] : (PARITY != PARITY_NONE) ? par_q : 1'b1;
         end
         ST_PARITY: tx_d = bit_done ? 1'b1 : tx_q;
         ST_STOP: if (bit_done) begin
            bit_cnt_d = last_stop ? '0 : bit_cnt_q + 3'd1;
            rdy_d     = last_stop;
            busy_d    = !last_stop;
         end
         default: tx_d = 1'b1;
      endcase
   end
   assign s_axis_tready = rdy_q;
   assign UART_TX       = tx_q;
   assign tx_busy       = busy_q;
endmodule
